// File: rtl/prop_serial_mon.sv
// Propeller TX-line receiver: 8N1 deserialiser feeding a small FWFT byte FIFO.
// Optional break detector is enabled by defining PROP_SERIAL_BREAK_EN.
module prop_serial_mon #(
    parameter int DIVISOR    = 1389,
    parameter int FIFO_DEPTH = 4,
    parameter int BREAK_BITS = 20
) (
    input  logic       clock_160,
    input  logic       inp_resn,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overflow,
    input  logic       clr_ovf,
    output logic       break_resn
);

    localparam int CW = $clog2(DIVISOR + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIVISOR - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    if (DIVISOR < 4 || FIFO_DEPTH < 2 || BREAK_BITS < 1 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("prop_serial_mon: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HI
    } state_t;

    logic          sync_reg, rxs_reg;
    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic          frame_err_reg, overflow_reg;
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0] level_reg, level_next;
    logic [7:0]    mem [FIFO_DEPTH];

    logic tick, push, ferr_set, pop, full, wr_en, ovf_set, brk_active;

    // Two-flop synchroniser; the line idles high.
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            sync_reg <= 1'b1;
            rxs_reg  <= 1'b1;
        end else begin
            sync_reg <= rx_pin;
            rxs_reg  <= sync_reg;
        end
    end

`ifdef PROP_SERIAL_BREAK_EN
    localparam int BRK_MAX = BREAK_BITS * DIVISOR;
    localparam int BW = $clog2(BRK_MAX + 1);
    logic [BW-1:0] brk_cnt_reg;

    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn)
            brk_cnt_reg <= '0;
        else if (rxs_reg)
            brk_cnt_reg <= '0;
        else if (brk_cnt_reg != BW'(BRK_MAX))
            brk_cnt_reg <= brk_cnt_reg + BW'(1);
    end

    assign brk_active = (brk_cnt_reg == BW'(BRK_MAX));
`else
    assign brk_active = 1'b0;
`endif

    assign break_resn = ~brk_active;
    assign tick       = (cnt_reg == '0);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        push         = 1'b0;
        ferr_set     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!rxs_reg) begin
                    cnt_next   = HALF_LOAD;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (!tick) begin
                    cnt_next = cnt_reg - CW'(1);
                end else if (rxs_reg) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next     = FULL_LOAD;
                    bit_idx_next = 3'd0;
                    state_next   = S_DATA;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    cnt_next = cnt_reg - CW'(1);
                end else begin
                    shift_next = {rxs_reg, shift_reg[7:1]};
                    cnt_next   = FULL_LOAD;
                    if (bit_idx_reg == 3'd7)
                        state_next = S_STOP;
                    else
                        bit_idx_next = bit_idx_reg + 3'd1;
                end
            end
            S_STOP: begin
                if (!tick) begin
                    cnt_next = cnt_reg - CW'(1);
                end else if (rxs_reg) begin
                    push       = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    ferr_set   = 1'b1;
                    state_next = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (rxs_reg)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // A break holds the receiver off the line until it goes high again.
        if (brk_active)
            state_next = S_WAIT_HI;
    end

    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            frame_err_reg <= ferr_set;
        end
    end

    // FIFO: when full, a push is only accepted if the head leaves the same cycle.
    assign rx_valid = (level_reg != '0);
    assign full     = (level_reg == LEVEL_FULL);
    assign pop      = rx_valid && rx_ready;
    assign wr_en    = push && (!full || pop);
    assign ovf_set  = push && full && !pop;

    always_comb begin
        level_next = level_reg;
        case ({wr_en, pop})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            level_reg <= level_next;
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (clr_ovf)
                overflow_reg <= 1'b0;
            else if (ovf_set)
                overflow_reg <= 1'b1;
        end
    end

    always_ff @(posedge clock_160) begin
        if (wr_en)
            mem[wr_ptr_reg] <= shift_reg;
    end

    assign rx_data   = rx_valid ? mem[rd_ptr_reg] : 8'h00;
    assign frame_err = frame_err_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_prop_serial_mon.sv
// Directed bench for prop_serial_mon (DIVISOR=16, FIFO_DEPTH=4, BREAK_BITS=20).
// Break expectations follow PROP_SERIAL_BREAK_EN.
module tb_prop_serial_mon;
    localparam int DIV = 16;

    logic       clock_160 = 1'b0;
    logic       inp_resn, rx_pin, rx_ready, clr_ovf;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overflow, break_resn;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got_q[$];
    int valid_cycles = 0;
    int ferr_cnt     = 0;

`ifdef PROP_SERIAL_BREAK_EN
    localparam logic BRK = 1'b1;
`else
    localparam logic BRK = 1'b0;
`endif

    prop_serial_mon #(.DIVISOR(DIV), .FIFO_DEPTH(4), .BREAK_BITS(20)) dut (
        .clock_160 (clock_160),
        .inp_resn  (inp_resn),
        .rx_pin    (rx_pin),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .break_resn(break_resn)
    );

    always #5 clock_160 = ~clock_160;

    // Records consumed bytes, valid cycles and frame-error pulses.
    always @(negedge clock_160) begin
        if (inp_resn) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (rx_valid) valid_cycles++;
            if (frame_err) ferr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // One 8N1 frame, 160 cycles; the stop sample lands on edge 154->155.
    task automatic send_byte(input logic [7:0] b, input logic stop_val, input logic ready_pulse);
        int bi;
        for (int c = 0; c < 10 * DIV; c++) begin
            @(posedge clock_160);
            #1;
            bi = c / DIV;
            if (bi == 0)      rx_pin = 1'b0;
            else if (bi <= 8) rx_pin = b[bi-1];
            else              rx_pin = stop_val;
            if (ready_pulse) rx_ready = (c == 154);
        end
        rx_pin = 1'b1;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        @(negedge clock_160);
        check({tag, "_valid"}, rx_valid, 1);
        check(tag, rx_data, exp);
        rx_ready = 1'b1;
        @(negedge clock_160);
        rx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock_160);
    endtask

    int q_base, v_base, f_base;

    initial begin
        inp_resn = 1'b0;
        rx_pin   = 1'b1;
        rx_ready = 1'b0;
        clr_ovf  = 1'b0;
        #12;
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 8'h00);
        check("rst_ferr", frame_err, 0);
        check("rst_ovf", overflow, 0);
        check("rst_brk", break_resn, 1);
        @(negedge clock_160);
        inp_resn = 1'b1;
        idle(5);

        // 1: single byte with consumer ready
        q_base = got_q.size(); v_base = valid_cycles; f_base = ferr_cnt;
        rx_ready = 1'b1;
        send_byte(8'h55, 1'b1, 1'b0);
        idle(4);
        check("t1_count", got_q.size() - q_base, 1);
        check("t1_data", got_q[q_base], 8'h55);
        check("t1_vcyc", valid_cycles - v_base, 1);
        check("t1_ferr", ferr_cnt - f_base, 0);

        // 2: short low glitch is rejected
        q_base = got_q.size(); f_base = ferr_cnt;
        @(posedge clock_160); #1 rx_pin = 1'b0;
        repeat (6) @(posedge clock_160);
        #1 rx_pin = 1'b1;
        idle(30);
        check("t2_count", got_q.size() - q_base, 0);
        check("t2_ferr", ferr_cnt - f_base, 0);
        check("t2_valid", rx_valid, 0);
        send_byte(8'hC6, 1'b1, 1'b0);
        idle(4);
        check("t2_after", got_q[q_base], 8'hC6);

        // 3: bad stop bit, then a good frame
        rx_ready = 1'b0;
        f_base = ferr_cnt;
        send_byte(8'hA3, 1'b0, 1'b0);
        idle(10);
        send_byte(8'h3C, 1'b1, 1'b0);
        idle(3);
        check("t3_ferr", ferr_cnt - f_base, 1);
        pop_check("t3_head", 8'h3C);
        check("t3_empty", rx_valid, 0);

        // 4: overflow with consumer stalled
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, 1'b0);
        idle(2);
        check("t4_ovf_4", overflow, 0);
        send_byte(8'h05, 1'b1, 1'b0);
        idle(2);
        check("t4_ovf_5", overflow, 1);
        @(negedge clock_160) clr_ovf = 1'b1;
        @(negedge clock_160) clr_ovf = 1'b0;
        check("t4_ovf_clr", overflow, 0);
        pop_check("t4_b1", 8'h01);
        pop_check("t4_b2", 8'h02);
        pop_check("t4_b3", 8'h03);
        pop_check("t4_b4", 8'h04);
        check("t4_empty", rx_valid, 0);

        // 5: push and pop together while full
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);
        send_byte(8'h44, 1'b1, 1'b0);
        send_byte(8'h66, 1'b1, 1'b1);
        idle(2);
        check("t5_ovf", overflow, 0);
        pop_check("t5_b1", 8'h22);
        pop_check("t5_b2", 8'h33);
        pop_check("t5_b3", 8'h44);
        pop_check("t5_b4", 8'h66);
        check("t5_empty", rx_valid, 0);

        // 6a: long low line (break when enabled)
        f_base = ferr_cnt;
        @(posedge clock_160); #1 rx_pin = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clock_160);
            #1;
            if (c == 321) check("t6_brk_321", break_resn, 1);
            if (c == 322) check("t6_brk_322", break_resn, !BRK);
        end
        rx_pin = 1'b1;
        @(posedge clock_160); #1;
        @(posedge clock_160); #1;
        check("t6_brk_hold", break_resn, !BRK);
        @(posedge clock_160); #1;
        check("t6_brk_rel", break_resn, 1);
        check("t6_ferr", ferr_cnt - f_base, 1);
        idle(20);
        q_base = got_q.size();
        rx_ready = 1'b1;
        send_byte(8'h81, 1'b1, 1'b0);
        idle(4);
        check("t6_after_brk", got_q[q_base], 8'h81);

        // 6b: asynchronous reset in the middle of a data bit
        rx_ready = 1'b0;
        send_byte(8'h5A, 1'b1, 1'b0);
        @(posedge clock_160); #1 rx_pin = 1'b0;
        repeat (40) @(posedge clock_160);
        @(negedge clock_160);
        check("t6_pre_valid", rx_valid, 1);
        inp_resn = 1'b0;
        #1;
        check("t6_rst_valid", rx_valid, 0);
        check("t6_rst_data", rx_data, 8'h00);
        check("t6_rst_ferr", frame_err, 0);
        check("t6_rst_ovf", overflow, 0);
        check("t6_rst_brk", break_resn, 1);
        rx_pin = 1'b1;
        idle(3);
        inp_resn = 1'b1;
        idle(5);
        check("t6_post_valid", rx_valid, 0);
        q_base = got_q.size();
        rx_ready = 1'b1;
        send_byte(8'h96, 1'b1, 1'b0);
        idle(4);
        check("t6_post_data", got_q[q_base], 8'h96);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
